// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point adder/subtractor for the {sign, exp, man} format.
// The operation runs as a sequence of states. Alignment and normalisation move
// one bit per cycle. Results use truncation rounding and a one-hot status code.
module fpu_addsub_param #(
    parameter int unsigned EXP_W = 6,
    parameter int unsigned MAN_W = 25
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_A_in,
    input  logic [EXP_W+MAN_W:0]     op_B_in,
    input  logic                     op_mode_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     data_out,
    output logic [3:0]               status_out
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MW = MAN_W + 2;   // carry + hidden + stored
    localparam int unsigned EW = EXP_W + 2;   // signed exponent, no wrap

    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] D_FLUSH = EW'(MAN_W + 1);
    localparam logic signed [EW-1:0] ONE     = EW'(1);

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0] ST_INEXACT   = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        PACK,
        DONE
    } state_t;

    state_t state, state_next;

    logic [W-1:0]          a_q, b_q;
    logic                  sx, sy, sticky;
    logic signed [EW-1:0]  ex, d;
    logic [MW-1:0]         mx, my;

    logic [EXP_W-1:0]      a_exp, b_exp;
    logic signed [EW-1:0]  ea, eb;
    logic [MW-1:0]         ma, mb;
    logic                  a_ge_b;

    // Unpack captured operands: zero detect, hidden bit, magnitude compare
    always_comb begin
        a_exp  = a_q[W-2 -: EXP_W];
        b_exp  = b_q[W-2 -: EXP_W];
        ea     = EW'(a_exp);
        eb     = EW'(b_exp);
        ma     = (a_exp != '0) ? {2'b01, a_q[MAN_W-1:0]} : '0;
        mb     = (b_exp != '0) ? {2'b01, b_q[MAN_W-1:0]} : '0;
        a_ge_b = (ea > eb) || ((ea == eb) && (ma >= mb));
    end

    // State register
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                state_next = (ea == eb) ? ADD : ALIGN;
            end
            ALIGN: begin
                if ((d > D_FLUSH) || (d == ONE)) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                state_next = NORM;
            end
            NORM: begin
                // Leave once there is no carry and the value is zero or normalised
                if (!mx[MW-1] && ((mx == '0) || mx[MAN_W])) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            sx         <= 1'b0;
            sy         <= 1'b0;
            sticky     <= 1'b0;
            ex         <= '0;
            d          <= '0;
            mx         <= '0;
            my         <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            in_ready <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q <= op_A_in;
                        b_q <= {op_B_in[W-1] ^ op_mode_in, op_B_in[W-2:0]};
                    end
                end
                UNPACK: begin
                    sticky <= 1'b0;
                    if (a_ge_b) begin
                        sx <= a_q[W-1];
                        ex <= ea;
                        mx <= ma;
                        sy <= b_q[W-1];
                        my <= mb;
                        d  <= ea - eb;
                    end else begin
                        sx <= b_q[W-1];
                        ex <= eb;
                        mx <= mb;
                        sy <= a_q[W-1];
                        my <= ma;
                        d  <= eb - ea;
                    end
                end
                ALIGN: begin
                    if (d > D_FLUSH) begin
                        sticky <= sticky | (|my);
                        my     <= '0;
                        d      <= '0;
                    end else begin
                        sticky <= sticky | my[0];
                        my     <= my >> 1;
                        d      <= d - ONE;
                    end
                end
                ADD: begin
                    mx <= (sx ^ sy) ? (mx - my) : (mx + my);
                end
                NORM: begin
                    if (mx[MW-1]) begin
                        sticky <= sticky | mx[0];
                        mx     <= mx >> 1;
                        ex     <= ex + ONE;
                    end else if ((mx != '0) && !mx[MAN_W]) begin
                        mx <= mx << 1;
                        ex <= ex - ONE;
                    end
                end
                PACK: begin
                    out_valid <= 1'b1;
                    if (ex > EXP_MAX) begin
                        data_out   <= {sx, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                        status_out <= ST_OVERFLOW;
                    end else if ((mx != '0) && (ex < ONE)) begin
                        data_out   <= '0;
                        status_out <= ST_UNDERFLOW;
                    end else if (mx == '0) begin
                        data_out   <= '0;
                        status_out <= sticky ? ST_INEXACT : ST_EXACT;
                    end else begin
                        data_out   <= {sx, ex[EXP_W-1:0], mx[MAN_W-1:0]};
                        status_out <= sticky ? ST_INEXACT : ST_EXACT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        status_out <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
